image_ram_stream_reader: RTL and testbench
==========================================

IMAGE_RAM_STREAM_READER -- requirements
Module: image_ram_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDR_BITS, default 10, RAM address width; RAM depth is 2**ADDR_BITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_BITS  first RAM address of burst; sampled with start.
REQ-007 length  input  ADDR_BITS+1  word count 0..2**ADDR_BITS; sampled with start.
REQ-008 read_address  output  ADDR_BITS  address to RAM with combinational read.
REQ-009 ram_data  input  WIDTH  RAM read data, valid same cycle as read_address.
REQ-010 m_data  output  WIDTH  stream data, registered.
REQ-011 m_valid  output  1  stream valid.
REQ-012 m_ready  input  1  stream ready from consumer.
REQ-013 m_last  output  1  marks final beat of burst.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN.
REQ-017 IDLE with start=1 at an edge SHALL latch addr=base_addr and count=length, then enter RUN if length!=0, else stay IDLE and pulse done next cycle.
REQ-018 read_address SHALL equal the internal addr register at all times.
REQ-019 Load condition: state==RUN && count!=0 && (!m_valid || m_ready).
REQ-020 On load: m_data<=ram_data, m_valid<=1, m_last<=(count==1), addr<=addr+1 mod 2**ADDR_BITS, count<=count-1.
REQ-021 When m_valid && m_ready and no load occurs in the same cycle, m_valid SHALL clear.
REQ-022 When the load with count==1 occurs, RUN SHALL enter DRAIN.
REQ-023 DRAIN with m_valid && m_ready && m_last SHALL clear m_valid and m_last, go to IDLE, and pulse done for exactly the following cycle.
REQ-024 m_data, m_valid and m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 Throughput SHALL be one beat per cycle with m_ready held high; the first m_valid SHALL rise at the second edge after start is sampled.
REQ-026 Address wrap from 2**ADDR_BITS-1 to 0 SHALL be seamless with no stall.
REQ-027 start while busy SHALL be ignored with no effect on the active burst.
REQ-028 length=2**ADDR_BITS SHALL read every RAM word exactly once.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE and set addr=0, count=0, m_data=0, m_valid=0, m_last=0, done=0, at any point in a burst.
REQ-030 After rst deasserts, no beat of an aborted burst SHALL be emitted.

Configuration
REQ-031 Macro IMAGE_READER_PAD_EN defined: each burst SHALL emit one zero word before and one zero word after the RAM words, for length+2 beats; m_last SHALL be on the trailing pad; length=0 SHALL give two zero beats followed by done.
REQ-032 Macro IMAGE_READER_PAD_EN undefined: exactly length beats SHALL be emitted, and no pad logic SHALL be synthesized.

Structure
REQ-033 Package image_reader_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the default WIDTH/ADDR_BITS constants.
REQ-034 The output register stage (m_data/m_valid/m_last, load and hold logic) SHALL be a sub-module image_reader_out_stage; the FSM, counters and pad logic stay in the top module.

Verification
REQ-035 base=5, length=4, m_ready=1, RAM[a]=a -> m_data 5,6,7,8 on consecutive cycles, m_last on 8, done one cycle after the final beat.
REQ-036 base=1022, length=4, ADDR_BITS=10 -> read_address sequence 1022,1023,0,1 and data in that order with no gap.
REQ-037 length=3, m_ready low on alternate cycles -> each word is held while stalled, 3 beats total, no duplicate or lost word.
REQ-038 length=0 -> no m_valid; done pulse one cycle after start; with IMAGE_READER_PAD_EN, beats 0,0 then done.
REQ-039 rst asserted mid-burst after 2 of 6 beats -> outputs zero immediately; after release, m_valid stays 0 until the next start.
REQ-040 start pulsed during an active burst of length 8 -> exactly 8 beats and one done pulse.

Source files
------------

// File: rtl/image_reader_pkg.sv
// Shared constants and state encoding for the image RAM stream reader.
package image_reader_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/image_reader_out_stage.sv
// Registered stream output stage: captures a word on load and holds it until the consumer accepts it.
module image_reader_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_valid <= 1'b1;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      // m_data is left as-is; only the qualifiers drop once the beat is taken
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/image_ram_stream_reader.sv
// Reads a burst of words from a combinational-read RAM and streams them out with valid/ready.
// Optional IMAGE_READER_PAD_EN wraps each burst with one leading and one trailing zero word.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a burst
// RUN   | fetching RAM words into the output stage
// DRAIN | final beat loaded, waiting for the consumer to take it
module image_ram_stream_reader
  import image_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic [ADDR_BITS-1:0] read_address,
  input  logic [WIDTH-1:0]     ram_data,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  reader_state_t        state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 load, load_last;
  logic [WIDTH-1:0]     load_data;
`ifdef IMAGE_READER_PAD_EN
  logic                 pre_q, pre_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef IMAGE_READER_PAD_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef IMAGE_READER_PAD_EN
      pre_q   <= pre_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_data = ram_data;
    load_last = 1'b0;
`ifdef IMAGE_READER_PAD_EN
    pre_d     = pre_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          count_d = length;
`ifdef IMAGE_READER_PAD_EN
          pre_d   = 1'b1;
          state_d = RUN;
`else
          if (length != '0) state_d = RUN;
          else              done_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        if (!m_valid || m_ready) begin
`ifdef IMAGE_READER_PAD_EN
          if (pre_q) begin
            load      = 1'b1;
            load_data = '0;
            pre_d     = 1'b0;
          end else if (count_q != '0) begin
            load    = 1'b1;
            addr_d  = addr_q + 1'b1;
            count_d = count_q - CNT_ONE;
          end else begin
            load      = 1'b1;
            load_data = '0;
            load_last = 1'b1;
            state_d   = DRAIN;
          end
`else
          if (count_q != '0) begin
            load      = 1'b1;
            load_last = (count_q == CNT_ONE);
            addr_d    = addr_q + 1'b1;
            count_d   = count_q - CNT_ONE;
            if (count_q == CNT_ONE) state_d = DRAIN;
          end
`endif
        end
      end
      DRAIN: begin
        if (m_valid && m_ready && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  image_reader_out_stage #(.WIDTH(WIDTH)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

  assign read_address = addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_image_ram_stream_reader.sv
// Randomized bench for image_ram_stream_reader (default build) against a queue-based burst model.
module tb_image_ram_stream_reader;

  localparam int W  = 8;
  localparam int AB = 10;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   length;
  logic [AB-1:0] read_address;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [DEPTH];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always_comb ram_data = mem[read_address];

  image_ram_stream_reader #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .read_address (read_address),
    .ram_data     (ram_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ready_mode: 0 always ready, 1 alternating, 2 random
  task automatic run_burst(input int base, input int len, input int ready_mode, input bit poke_start);
    int exp_q[$];
    int n = 0, beats = 0, dones = 0, done_at = -1, first_v = -1, last_hs = -1;
    int budget = 4 * len + 24;
    bit prev_stall = 0;
    int prev_data = 0, prev_last = 0, exp_word;
    for (int i = 0; i < len; i++) exp_q.push_back(int'(mem[(base + i) % DEPTH]));

    @(negedge clk);
    base_addr = AB'(base);
    length    = (AB+1)'(len);
    start     = 1'b1;
    m_ready   = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      start = poke_start && (n == 3);
      if (poke_start && n == 3) begin
        base_addr = AB'($urandom_range(0, DEPTH-1));
        length    = (AB+1)'($urandom_range(1, 5));
      end
      if (n == 1 && len > 0) chk_eq("first_addr", int'(read_address), base);
      if (done) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      if (prev_stall) begin
        chk_eq("hold_valid", int'(m_valid), 1);
        chk_eq("hold_data", int'(m_data), prev_data);
        chk_eq("hold_last", int'(m_last), prev_last);
      end
      if (m_valid && first_v < 0) first_v = n;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = n[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_beat", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          chk_eq("beat_data", int'(m_data), exp_word);
          chk_eq("beat_last", int'(m_last), (exp_q.size() == 0) ? 1 : 0);
        end
        beats++;
        last_hs = n;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = int'(m_data);
      prev_last  = int'(m_last);
      if (done_at > 0 && n >= done_at + 3) break;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk_eq("done_seen", (done_at > 0) ? 1 : 0, 1);
    chk_eq("beat_count", beats, len);
    chk_eq("done_count", dones, 1);
    if (len == 0) begin
      chk_eq("len0_done_at", done_at, 1);
      chk_eq("len0_no_valid", first_v, -1);
    end else begin
      chk_eq("done_after_last", done_at, last_hs + 1);
      if (ready_mode == 0) begin
        chk_eq("first_valid_at", first_v, 2);
        chk_eq("full_rate_done_at", done_at, len + 2);
      end
    end
    chk_eq("idle_after", int'(busy), 0);
  endtask

  task automatic reset_mid_burst();
    int beats = 0, n = 0;
    bit leaked = 0;
    @(negedge clk);
    base_addr = AB'(100);
    length    = (AB+1)'(6);
    start     = 1'b1;
    m_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (beats < 2 && n < 20) begin
      if (m_valid && m_ready) beats++;
      @(negedge clk);
      n++;
    end
    chk_eq("rst_pre_beats", beats, 2);
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_valid", int'(m_valid), 0);
    chk_eq("rst_data", int'(m_data), 0);
    chk_eq("rst_last", int'(m_last), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_addr", int'(read_address), 0);
    chk_eq("rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid || busy || done) leaked = 1;
    end
    chk_eq("rst_no_resume", int'(leaked), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    for (int a = 0; a < DEPTH; a++) mem[a] = W'(a);
    #1;
    chk_eq("reset_valid", int'(m_valid), 0);
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_done", int'(done), 0);
    chk_eq("reset_addr", int'(read_address), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_burst(5, 4, 0, 0);
    run_burst(1022, 4, 0, 0);
    run_burst(17, 3, 1, 0);
    run_burst(300, 0, 0, 0);
    run_burst(40, 8, 0, 1);
    reset_mid_burst();

    for (int a = 0; a < DEPTH; a++) mem[a] = W'($urandom);
    for (int t = 0; t < 10; t++)
      run_burst($urandom_range(0, DEPTH-1), $urandom_range(0, 20), $urandom_range(0, 2), 0);
    run_burst(1020, 9, 2, 0);
    run_burst($urandom_range(0, DEPTH-1), DEPTH, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
